ix_sched: RTL and testbench

Issue-stage scheduler between the decoder's registered outputs and the execution units. It holds the decoded instruction until its source and destination registers are free, using a per-register scoreboard. It limits the number of in-flight instructions and sequences fence.i: drain, I-cache invalidate handshake, then issue. Instruction payload passes from the decoder to execution unchanged; this block owns only the valid/ready path.

---
 rtl/ix_sched_pkg.sv | 20 ++
 rtl/ix_scoreboard.sv | 45 ++++
 rtl/ix_sched.sv | 149 ++++++++++++++
 tb/tb_ix_sched.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ix_sched_pkg.sv
// Shared definitions for the issue-stage scheduler: FSM encoding, default
// in-flight limit and a register-index mask helper.
package ix_sched_pkg;

    localparam int IX_INFLIGHT_MAX = 4;
    localparam int IX_NREGS        = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_FI_REQ   = 3'd2,
        ST_FI_WAIT  = 3'd3,
        ST_FI_ISSUE = 3'd4
    } ix_state_t;

    function automatic logic [IX_NREGS-1:0] reg_mask(input logic [4:0] idx);
        return IX_NREGS'(1) << idx;
    endfunction

endpackage

// File: rtl/ix_scoreboard.sv
// Per-register busy scoreboard: one bit per architectural register, set on
// issue, cleared on writeback, with x0 hard-wired to not-busy.
module ix_scoreboard
    import ix_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        clr_en,
    input  logic [4:0]  clr_rd,
    output logic [31:0] busy,
    output logic        hazard
);

    logic [IX_NREGS-1:0] busy_q;
    logic [IX_NREGS-1:0] busy_d;

    // Clear is applied before set so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d = busy_d & ~reg_mask(clr_rd);
        end
        if (set_en) begin
            busy_d = busy_d | reg_mask(set_rd);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[rs1] | busy_q[rs2] | busy_q[rd];

endmodule

// File: rtl/ix_sched.sv
// Issue-stage scheduler: holds the decoded instruction until its registers are
// free and the in-flight limit allows, and sequences fence.i.
module ix_sched
    import ix_sched_pkg::*;
#(
    parameter int INFLIGHT_MAX = IX_INFLIGHT_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_flush,
    input  logic        dec_ix_valid,
    output logic        dec_ix_ready,
    input  logic [4:0]  dec_ix_rs1,
    input  logic [4:0]  dec_ix_rs2,
    input  logic [4:0]  dec_ix_rd,
    input  logic        dec_ix_wb_en,
    input  logic        dec_ix_legal,
    input  logic        dec_ix_fencei,
    output logic        ix_ex_valid,
    input  logic        ix_ex_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        retire_valid,
    output logic        fencei_req,
    input  logic        fencei_done,
    output logic [31:0] sb_busy,
    output logic        ix_stall
);

    ix_state_t  state;
    ix_state_t  state_next;
    logic [3:0] inflight;
    logic       fi_flushed;
    logic       sb_hazard;
    logic       hazard;
    logic       full;
    logic       fire;
    logic       retire_ok;
    logic       set_en;

    assign hazard    = dec_ix_valid && sb_hazard;
    assign full      = (inflight == 4'(INFLIGHT_MAX));
    assign fire      = ix_ex_valid && ix_ex_ready;
    assign retire_ok = retire_valid && (inflight != 4'd0);
    assign set_en    = fire && dec_ix_wb_en && dec_ix_legal && (dec_ix_rd != 5'd0);

    ix_scoreboard u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .rs1    (dec_ix_rs1),
        .rs2    (dec_ix_rs2),
        .rd     (dec_ix_rd),
        .set_en (set_en),
        .set_rd (dec_ix_rd),
        .clr_en (wb_valid),
        .clr_rd (wb_rd),
        .busy   (sb_busy),
        .hazard (sb_hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A flush while the invalidate is outstanding still lets it complete, but
    // the held fence.i must not issue once FI_ISSUE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            fi_flushed <= 1'b0;
        end else if ((state == ST_FI_REQ || state == ST_FI_WAIT) && pipe_flush) begin
            fi_flushed <= 1'b1;
        end else if (state == ST_IDLE) begin
            fi_flushed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 4'd0;
        end else begin
            case ({fire, retire_ok})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (dec_ix_valid && dec_ix_fencei && !pipe_flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_flush) begin
                    state_next = ST_IDLE;
                end else if (inflight == 4'd0) begin
                    state_next = ST_FI_REQ;
                end
            end
            ST_FI_REQ: begin
                state_next = ST_FI_WAIT;
            end
            ST_FI_WAIT: begin
                if (fencei_done) begin
                    state_next = ST_FI_ISSUE;
                end
            end
            ST_FI_ISSUE: begin
                if (fire || pipe_flush || !dec_ix_valid || fi_flushed) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ix_ex_valid = 1'b0;
        fencei_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                ix_ex_valid = dec_ix_valid && !pipe_flush && !hazard && !full && !dec_ix_fencei;
            end
            ST_FI_REQ: begin
                fencei_req = 1'b1;
            end
            ST_FI_ISSUE: begin
                ix_ex_valid = dec_ix_valid && !pipe_flush && !fi_flushed;
            end
            default: begin
                ix_ex_valid = 1'b0;
            end
        endcase
    end

    assign dec_ix_ready = fire || !dec_ix_valid || pipe_flush;
    assign ix_stall     = dec_ix_valid && !pipe_flush && !fire;

endmodule

// File: tb/tb_ix_sched.sv
// Self-checking bench for ix_sched: expected issues are queued when an
// instruction is presented and matched against each observed fire.
module tb_ix_sched;

    logic        clk;
    logic        rst;
    logic        pipe_flush;
    logic        dec_ix_valid;
    logic        dec_ix_ready;
    logic [4:0]  dec_ix_rs1;
    logic [4:0]  dec_ix_rs2;
    logic [4:0]  dec_ix_rd;
    logic        dec_ix_wb_en;
    logic        dec_ix_legal;
    logic        dec_ix_fencei;
    logic        ix_ex_valid;
    logic        ix_ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        retire_valid;
    logic        fencei_req;
    logic        fencei_done;
    logic [31:0] sb_busy;
    logic        ix_stall;

    typedef struct {
        logic [4:0] rd;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cycle;

    ix_sched #(.INFLIGHT_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_flush   (pipe_flush),
        .dec_ix_valid (dec_ix_valid),
        .dec_ix_ready (dec_ix_ready),
        .dec_ix_rs1   (dec_ix_rs1),
        .dec_ix_rs2   (dec_ix_rs2),
        .dec_ix_rd    (dec_ix_rd),
        .dec_ix_wb_en (dec_ix_wb_en),
        .dec_ix_legal (dec_ix_legal),
        .dec_ix_fencei(dec_ix_fencei),
        .ix_ex_valid  (ix_ex_valid),
        .ix_ex_ready  (ix_ex_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .retire_valid (retire_valid),
        .fencei_req   (fencei_req),
        .fencei_done  (fencei_done),
        .sb_busy      (sb_busy),
        .ix_stall     (ix_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic wb_en, input logic legal, input logic fencei);
        dec_ix_valid  = 1'b1;
        dec_ix_rs1    = rs1;
        dec_ix_rs2    = rs2;
        dec_ix_rd     = rd;
        dec_ix_wb_en  = wb_en;
        dec_ix_legal  = legal;
        dec_ix_fencei = fencei;
    endtask

    task automatic idleDecoder();
        dec_ix_valid  = 1'b0;
        dec_ix_rs1    = 5'd0;
        dec_ix_rs2    = 5'd0;
        dec_ix_rd     = 5'd0;
        dec_ix_wb_en  = 1'b0;
        dec_ix_legal  = 1'b1;
        dec_ix_fencei = 1'b0;
    endtask

    task automatic expectFire(input logic [4:0] rd, input int cyc);
        exp_t e;
        e.rd  = rd;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic retireN(input int n);
        retire_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            midCycle();
            nextCycle();
        end
        retire_valid = 1'b0;
    endtask

    // Every fire must match the oldest queued expectation in register and cycle.
    always @(negedge clk) begin
        if (!rst && ix_ex_valid && ix_ex_ready) begin
            checkOutput("fire_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("fire_rd", 32'(dec_ix_rd), 32'(e.rd));
                checkOutput("fire_cycle", cycle, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int r;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        pipe_flush   = 1'b0;
        ix_ex_ready  = 1'b1;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        retire_valid = 1'b0;
        fencei_done  = 1'b0;
        idleDecoder();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        midCycle();
        checkOutput("rst_busy", sb_busy, 32'h0);
        checkOutput("rst_valid", 32'(ix_ex_valid), 32'd0);
        checkOutput("rst_req", 32'(fencei_req), 32'd0);
        checkOutput("rst_stall", 32'(ix_stall), 32'd0);
        checkOutput("rst_ready", 32'(dec_ix_ready), 32'd1);
        nextCycle();

        // Back-to-back independent instructions rd=1,2,3
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(5'd0, 5'd0, 5'(i), 1'b1, 1'b1, 1'b0);
            expectFire(5'(i), cycle);
            midCycle();
            checkOutput("b2b_ready", 32'(dec_ix_ready), 32'd1);
            nextCycle();
        end
        idleDecoder();
        midCycle();
        checkOutput("b2b_busy", sb_busy, 32'h0000000E);
        nextCycle();
        wb_valid = 1'b1;
        retire_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wb_rd = 5'(i);
            midCycle();
            nextCycle();
        end
        wb_valid = 1'b0;
        retire_valid = 1'b0;
        midCycle();
        checkOutput("b2b_clear", sb_busy, 32'h0);
        nextCycle();

        // RAW hazard on rd=5, released one cycle after writeback
        applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        expectFire(5'd5, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        midCycle();
        checkOutput("raw_stall", 32'(ix_stall), 32'd1);
        checkOutput("raw_ready", 32'(dec_ix_ready), 32'd0);
        nextCycle();
        midCycle();
        checkOutput("raw_stall2", 32'(ix_stall), 32'd1);
        nextCycle();
        wb_valid = 1'b1;
        wb_rd = 5'd5;
        expectFire(5'd6, cycle + 1);
        midCycle();
        checkOutput("raw_no_bypass", 32'(ix_ex_valid), 32'd0);
        nextCycle();
        wb_valid = 1'b0;
        midCycle();
        checkOutput("raw_release", 32'(ix_ex_valid), 32'd1);
        checkOutput("raw_release_stall", 32'(ix_stall), 32'd0);
        nextCycle();
        idleDecoder();
        midCycle();
        checkOutput("raw_busy", sb_busy, 32'h00000040);
        nextCycle();
        wb_valid = 1'b1;
        wb_rd = 5'd6;
        retire_valid = 1'b1;
        midCycle();
        nextCycle();
        wb_valid = 1'b0;
        midCycle();
        nextCycle();
        retire_valid = 1'b0;

        // rs2 hazard is checked as well
        applyStimulus(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0);
        expectFire(5'd20, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd0, 5'd20, 5'd21, 1'b0, 1'b1, 1'b0);
        midCycle();
        checkOutput("rs2_stall", 32'(ix_stall), 32'd1);
        nextCycle();
        wb_valid = 1'b1;
        wb_rd = 5'd20;
        expectFire(5'd21, cycle + 1);
        midCycle();
        nextCycle();
        wb_valid = 1'b0;
        midCycle();
        nextCycle();
        idleDecoder();
        retireN(2);

        // In-flight limit: fifth instruction waits for a retire, no same-cycle credit
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 5'd0, 5'(8 + i), 1'b0, 1'b1, 1'b0);
            expectFire(5'(8 + i), cycle);
            midCycle();
            nextCycle();
        end
        applyStimulus(5'd0, 5'd0, 5'd12, 1'b0, 1'b1, 1'b0);
        midCycle();
        checkOutput("full_stall", 32'(ix_stall), 32'd1);
        checkOutput("full_valid", 32'(ix_ex_valid), 32'd0);
        nextCycle();
        retire_valid = 1'b1;
        expectFire(5'd12, cycle + 1);
        midCycle();
        checkOutput("full_no_credit", 32'(ix_ex_valid), 32'd0);
        nextCycle();
        retire_valid = 1'b0;
        midCycle();
        checkOutput("full_release", 32'(ix_ex_valid), 32'd1);
        nextCycle();
        idleDecoder();
        retireN(4);

        // rd=0 and illegal instructions never mark the scoreboard
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        expectFire(5'd0, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        expectFire(5'd9, cycle);
        midCycle();
        nextCycle();
        idleDecoder();
        midCycle();
        checkOutput("nobusy_rd0_illegal", sb_busy, 32'h0);
        nextCycle();
        retireN(2);

        // Same-cycle set and clear of rd=7: set wins
        applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        expectFire(5'd7, cycle);
        midCycle();
        nextCycle();
        wb_valid = 1'b0;
        idleDecoder();
        midCycle();
        checkOutput("set_wins", sb_busy, 32'h00000080);
        nextCycle();
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        retire_valid = 1'b1;
        midCycle();
        nextCycle();
        wb_valid = 1'b0;
        retire_valid = 1'b0;

        // fence.i with two in flight: drain, one-cycle request, done 3 cycles later
        applyStimulus(5'd0, 5'd0, 5'd13, 1'b0, 1'b1, 1'b0);
        expectFire(5'd13, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd14, 1'b0, 1'b1, 1'b0);
        expectFire(5'd14, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        midCycle();
        checkOutput("fi_idle_valid", 32'(ix_ex_valid), 32'd0);
        checkOutput("fi_idle_stall", 32'(ix_stall), 32'd1);
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            midCycle();
            checkOutput("fi_drain_valid", 32'(ix_ex_valid), 32'd0);
            checkOutput("fi_drain_req", 32'(fencei_req), 32'd0);
            nextCycle();
        end
        r = cycle;
        retireN(2);
        midCycle();
        checkOutput("fi_req_early", 32'(fencei_req), 32'd0);
        nextCycle();
        midCycle();
        checkOutput("fi_req_cycle", cycle, r + 3);
        checkOutput("fi_req", 32'(fencei_req), 32'd1);
        checkOutput("fi_req_valid", 32'(ix_ex_valid), 32'd0);
        nextCycle();
        midCycle();
        checkOutput("fi_req_one", 32'(fencei_req), 32'd0);
        nextCycle();
        midCycle();
        nextCycle();
        fencei_done = 1'b1;
        expectFire(5'd0, cycle + 1);
        midCycle();
        checkOutput("fi_wait_valid", 32'(ix_ex_valid), 32'd0);
        nextCycle();
        fencei_done = 1'b0;
        midCycle();
        checkOutput("fi_issue_valid", 32'(ix_ex_valid), 32'd1);
        nextCycle();
        idleDecoder();
        retireN(1);

        // pipe_flush in DRAIN returns to IDLE
        applyStimulus(5'd0, 5'd0, 5'd15, 1'b0, 1'b1, 1'b0);
        expectFire(5'd15, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        midCycle();
        nextCycle();
        pipe_flush = 1'b1;
        midCycle();
        checkOutput("drain_flush_ready", 32'(dec_ix_ready), 32'd1);
        checkOutput("drain_flush_stall", 32'(ix_stall), 32'd0);
        nextCycle();
        pipe_flush = 1'b0;
        applyStimulus(5'd0, 5'd0, 5'd16, 1'b0, 1'b1, 1'b0);
        expectFire(5'd16, cycle);
        midCycle();
        checkOutput("drain_flush_idle", 32'(ix_ex_valid), 32'd1);
        checkOutput("drain_flush_req", 32'(fencei_req), 32'd0);
        nextCycle();
        idleDecoder();
        retireN(2);

        // pipe_flush in FI_WAIT: invalidate completes, nothing issues, back to IDLE
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        g = cycle;
        midCycle();
        nextCycle();
        midCycle();
        nextCycle();
        midCycle();
        checkOutput("fw_req_cycle", cycle, g + 2);
        checkOutput("fw_req", 32'(fencei_req), 32'd1);
        nextCycle();
        pipe_flush = 1'b1;
        midCycle();
        checkOutput("fw_flush_ready", 32'(dec_ix_ready), 32'd1);
        nextCycle();
        pipe_flush = 1'b0;
        midCycle();
        checkOutput("fw_wait_valid", 32'(ix_ex_valid), 32'd0);
        nextCycle();
        fencei_done = 1'b1;
        midCycle();
        nextCycle();
        fencei_done = 1'b0;
        midCycle();
        checkOutput("fw_issue_blocked", 32'(ix_ex_valid), 32'd0);
        checkOutput("fw_issue_stall", 32'(ix_stall), 32'd1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd17, 1'b0, 1'b1, 1'b0);
        expectFire(5'd17, cycle);
        midCycle();
        checkOutput("fw_back_idle", 32'(ix_ex_valid), 32'd1);
        nextCycle();
        idleDecoder();
        retireN(1);

        // Reset during fence.i clears the scoreboard and returns to IDLE
        applyStimulus(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        expectFire(5'd4, cycle);
        midCycle();
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        midCycle();
        nextCycle();
        rst = 1'b1;
        idleDecoder();
        midCycle();
        nextCycle();
        rst = 1'b0;
        midCycle();
        checkOutput("mid_rst_busy", sb_busy, 32'h0);
        checkOutput("mid_rst_req", 32'(fencei_req), 32'd0);
        checkOutput("mid_rst_ready", 32'(dec_ix_ready), 32'd1);
        nextCycle();
        applyStimulus(5'd4, 5'd0, 5'd18, 1'b0, 1'b1, 1'b0);
        expectFire(5'd18, cycle);
        midCycle();
        checkOutput("mid_rst_issue", 32'(ix_ex_valid), 32'd1);
        nextCycle();
        idleDecoder();
        retireN(1);

        midCycle();
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
